// File: rtl/segre_tlb_walker.sv
// Single-level hardware page-table walker behind segre_tlb: fetches one PTE per
// TLB miss through a single read port, then either fills the TLB or raises a fault.
module segre_tlb_walker #(
  parameter int VADDR_SIZE = 20,
  parameter int PADDR_SIZE = 8,
  parameter int ADDR_SIZE  = 32
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  miss_i,
  input  logic [VADDR_SIZE-1:0] vaddr_i,
  input  logic [1:0]            access_type_i,
  input  logic [ADDR_SIZE-1:0]  ptbr_i,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  output logic [ADDR_SIZE-1:0]  mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  tlb_new_entry_o,
  output logic [VADDR_SIZE-1:0] tlb_vaddr_o,
  output logic [PADDR_SIZE-1:0] tlb_paddr_o,
  output logic [1:0]            tlb_prot_o,
  output logic                  busy_o,
  output logic                  page_fault_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] FILL  = 3'd4;
  localparam logic [2:0] FAULT = 3'd5;

  localparam logic [1:0] PROT_R = 2'd0;

  logic [2:0]            state_q;
  logic [2:0]            state_d;
  logic [VADDR_SIZE-1:0] vpn_q;
  logic [ADDR_SIZE-1:0]  ptbr_q;
  logic [1:0]            access_q;
  logic [VADDR_SIZE-1:0] tlb_vaddr_q;
  logic [PADDR_SIZE-1:0] tlb_paddr_q;
  logic [1:0]            tlb_prot_q;

  logic start_walk;
  logic pte_valid;
  logic capture_pte;
  logic unused_bits;

  assign start_walk  = (state_q == IDLE) && miss_i && !flush_i;
  assign pte_valid   = mem_rdata_i[31];
  assign capture_pte = (state_q == WAIT) && mem_rvalid_i && !flush_i && pte_valid;

  // The access type and the ignored PTE bits are carried but not consumed here.
  assign unused_bits = ^{access_q, mem_rdata_i};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_walk) state_d = REQ;
      end
      REQ: begin
        if (mem_gnt_i)    state_d = flush_i ? DRAIN : WAIT;
        else if (flush_i) state_d = IDLE;
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          if (flush_i)        state_d = IDLE;
          else if (pte_valid) state_d = FILL;
          else                state_d = FAULT;
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      FILL:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q  <= IDLE;
      vpn_q    <= '0;
      ptbr_q   <= '0;
      access_q <= PROT_R;
    end else begin
      state_q <= state_d;
      if (start_walk) begin
        vpn_q    <= vaddr_i;
        ptbr_q   <= ptbr_i;
        access_q <= access_type_i;
      end
    end
  end

  // TLB write data only changes on a valid PTE, so it holds between fills.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      tlb_vaddr_q <= '0;
      tlb_paddr_q <= '0;
      tlb_prot_q  <= PROT_R;
    end else if (capture_pte) begin
      tlb_vaddr_q <= vpn_q;
      tlb_paddr_q <= mem_rdata_i[PADDR_SIZE-1:0];
      tlb_prot_q  <= mem_rdata_i[9:8];
    end
  end

  assign mem_req_o  = (state_q == REQ);
  assign mem_addr_o = ptbr_q + (ADDR_SIZE'(vpn_q) << 2);
  assign busy_o     = (state_q != IDLE);

  // The TLB favours new_entry over invalidate, so a flush must mask the strobes.
  assign tlb_new_entry_o = (state_q == FILL) && !flush_i;
  assign page_fault_o    = (state_q == FAULT) && !flush_i;

  assign tlb_vaddr_o = tlb_vaddr_q;
  assign tlb_paddr_o = tlb_paddr_q;
  assign tlb_prot_o  = tlb_prot_q;

endmodule

// File: tb/tb_segre_tlb_walker.sv
// Directed bench for segre_tlb_walker: drives walks in one initial block and
// scores TLB fills / page faults against a queue of expected results.
`timescale 1ns/1ps
module tb_segre_tlb_walker;

  logic        clk_i = 1'b0;
  logic        rsn_i;
  logic        miss_i;
  logic [19:0] vaddr_i;
  logic [1:0]  access_type_i;
  logic [31:0] ptbr_i;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        tlb_new_entry_o;
  logic [19:0] tlb_vaddr_o;
  logic [7:0]  tlb_paddr_o;
  logic [1:0]  tlb_prot_o;
  logic        busy_o;
  logic        page_fault_o;

  typedef struct {
    bit          fault;
    logic [19:0] vpn;
    logic [7:0]  ppn;
    logic [1:0]  prot;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   req_count = 0;

  segre_tlb_walker #(.VADDR_SIZE(20), .PADDR_SIZE(8), .ADDR_SIZE(32)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .miss_i(miss_i), .vaddr_i(vaddr_i),
    .access_type_i(access_type_i), .ptbr_i(ptbr_i), .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .tlb_new_entry_o(tlb_new_entry_o), .tlb_vaddr_o(tlb_vaddr_o),
    .tlb_paddr_o(tlb_paddr_o), .tlb_prot_o(tlb_prot_o), .busy_o(busy_o),
    .page_fault_o(page_fault_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard side: every fill or fault strobe must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rsn_i === 1'b1) begin
      if (mem_req_o && mem_gnt_i) req_count++;
      if (tlb_new_entry_o || page_fault_o) begin
        check_output("sb_expected_present", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check_output("strobe_kind", {62'd0, tlb_new_entry_o, page_fault_o},
                       {62'd0, !e.fault, e.fault});
          check_output("strobe_cycle", 64'(cyc), 64'(e.cyc));
          if (!e.fault) begin
            check_output("tlb_vaddr", 64'(tlb_vaddr_o), 64'(e.vpn));
            check_output("tlb_paddr", 64'(tlb_paddr_o), 64'(e.ppn));
            check_output("tlb_prot",  64'(tlb_prot_o),  64'(e.prot));
          end
        end
      end
    end
  end

  // One full walk; optional miss pulses during the rvalid stall must be ignored.
  task automatic apply_stimulus(input logic [31:0] base, input logic [19:0] vpn,
                                input logic [31:0] pte, input int gnt_dly,
                                input int rv_dly, input bit pulse_miss);
    exp_t        e;
    logic [31:0] exp_addr;
    int          req_before;
    exp_addr   = base + (32'(vpn) << 2);
    req_before = req_count;
    step();
    miss_i        = 1'b1;
    vaddr_i       = vpn;
    ptbr_i        = base;
    access_type_i = 2'd1;
    e.fault = !pte[31];
    e.vpn   = vpn;
    e.ppn   = pte[7:0];
    e.prot  = pte[9:8];
    e.cyc   = cyc + 3 + gnt_dly + rv_dly;
    sb.push_back(e);
    step();
    miss_i  = 1'b0;
    vaddr_i = 20'hFFFFF;
    ptbr_i  = 32'h0;
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk_i);
      check_output("req_stall", 64'(mem_req_o), 64'd1);
      check_output("addr_stall", 64'(mem_addr_o), 64'(exp_addr));
      step();
    end
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    check_output("req_grant", 64'(mem_req_o), 64'd1);
    check_output("addr_grant", 64'(mem_addr_o), 64'(exp_addr));
    check_output("busy_req", 64'(busy_o), 64'd1);
    step();
    mem_gnt_i = 1'b0;
    for (int i = 0; i < rv_dly; i++) begin
      miss_i  = pulse_miss;
      vaddr_i = 20'h00BAD;
      @(negedge clk_i);
      check_output("req_wait", 64'(mem_req_o), 64'd0);
      step();
    end
    miss_i       = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = pte;
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    @(negedge clk_i);
    check_output("busy_fill", 64'(busy_o), 64'd1);
    step();
    @(negedge clk_i);
    check_output("busy_idle", 64'(busy_o), 64'd0);
    check_output("one_request", 64'(req_count - req_before), 64'd1);
    step();
    @(negedge clk_i);
    check_output("stay_idle", 64'(busy_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rsn_i = 1'b0; miss_i = 1'b0; vaddr_i = '0; access_type_i = '0; ptbr_i = '0;
    flush_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    step();
    @(negedge clk_i);
    check_output("rst_req", 64'(mem_req_o), 64'd0);
    check_output("rst_busy", 64'(busy_o), 64'd0);
    check_output("rst_fill", 64'(tlb_new_entry_o), 64'd0);
    check_output("rst_fault", 64'(page_fault_o), 64'd0);
    check_output("rst_addr", 64'(mem_addr_o), 64'd0);
    check_output("rst_tlb", {tlb_vaddr_o, tlb_paddr_o, tlb_prot_o}, 64'd0);
    step();
    rsn_i = 1'b1;

    $display("[TB] hit path");
    apply_stimulus(32'h0000_1000, 20'h0000A, 32'h8000_020B, 0, 0, 1'b0);
    $display("[TB] invalid PTE");
    apply_stimulus(32'h0000_1000, 20'h00011, 32'h0000_020B, 0, 0, 1'b0);
    $display("[TB] grant and rvalid stalls, miss pulsed while busy");
    apply_stimulus(32'h0000_2000, 20'h00123, 32'h8000_0155, 3, 2, 1'b1);
    $display("[TB] address wrap");
    apply_stimulus(32'hFFFF_FFF0, 20'h00005, 32'h8000_0301, 0, 0, 1'b0);

    $display("[TB] flush in REQ without grant");
    begin
      int rb;
      rb = req_count;
      step(); miss_i = 1'b1; vaddr_i = 20'h00042; ptbr_i = 32'h3000;
      step(); miss_i = 1'b0; flush_i = 1'b1;
      @(negedge clk_i);
      check_output("flush_req_req", 64'(mem_req_o), 64'd1);
      step(); flush_i = 1'b0;
      @(negedge clk_i);
      check_output("flush_req_idle", 64'(busy_o), 64'd0);
      check_output("flush_req_noreq", 64'(mem_req_o), 64'd0);
      check_output("flush_req_traffic", 64'(req_count - rb), 64'd0);
    end

    $display("[TB] flush in grant cycle");
    step(); miss_i = 1'b1; vaddr_i = 20'h00043; ptbr_i = 32'h3000;
    step(); miss_i = 1'b0; mem_gnt_i = 1'b1; flush_i = 1'b1;
    step(); mem_gnt_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    check_output("drain_busy", 64'(busy_o), 64'd1);
    check_output("drain_noreq", 64'(mem_req_o), 64'd0);
    step();
    @(negedge clk_i);
    check_output("drain_hold", 64'(busy_o), 64'd1);
    step(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h8000_0377;
    step(); mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    @(negedge clk_i);
    check_output("drain_idle", 64'(busy_o), 64'd0);

    $display("[TB] flush during FILL");
    step(); miss_i = 1'b1; vaddr_i = 20'h00044; ptbr_i = 32'h3000;
    step(); miss_i = 1'b0; mem_gnt_i = 1'b1;
    step(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h8000_0166;
    step(); mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; flush_i = 1'b1;
    @(negedge clk_i);
    check_output("fill_masked", 64'(tlb_new_entry_o), 64'd0);
    check_output("fill_busy", 64'(busy_o), 64'd1);
    step(); flush_i = 1'b0;
    @(negedge clk_i);
    check_output("fill_flush_idle", 64'(busy_o), 64'd0);

    $display("[TB] reset in WAIT");
    step(); miss_i = 1'b1; vaddr_i = 20'h00045; ptbr_i = 32'h4000;
    step(); miss_i = 1'b0; mem_gnt_i = 1'b1;
    step(); mem_gnt_i = 1'b0;
    @(negedge clk_i);
    check_output("wait_busy", 64'(busy_o), 64'd1);
    #1 rsn_i = 1'b0;
    #1;
    check_output("rstw_busy", 64'(busy_o), 64'd0);
    check_output("rstw_req", 64'(mem_req_o), 64'd0);
    check_output("rstw_addr", 64'(mem_addr_o), 64'd0);
    check_output("rstw_tlb", {tlb_vaddr_o, tlb_paddr_o, tlb_prot_o}, 64'd0);
    step(); rsn_i = 1'b1;
    step(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h8000_0199;
    step(); mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    @(negedge clk_i);
    check_output("rstw_idle", 64'(busy_o), 64'd0);
    check_output("rstw_tlb_after", {tlb_vaddr_o, tlb_paddr_o, tlb_prot_o}, 64'd0);
    step(); step();

    check_output("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/segre_tlb_walker.md
# segre_tlb_walker

Hardware page-table walker that sits directly downstream of `segre_tlb`. It consumes the TLB miss for the current access and fetches the page-table entry (PTE) from memory through a single read port. It then either writes a new translation into the TLB through the TLB's write port or raises a page fault. The translation is a single-level table: one 32-bit PTE per virtual page number, indexed from a page-table base register.

## Interface
Parameters:
- `VADDR_SIZE`, default 20: virtual page number width, same value as the TLB.
- `PADDR_SIZE`, default 8: physical page number width, same value as the TLB.
- `ADDR_SIZE`, default 32: memory byte-address width.

Ports (clock and reset first; reset is asynchronous and active-low):
- `clk_i` input, 1: the single clock.
- `rsn_i` input, 1: reset, asynchronous, active-low.
- `miss_i` input, 1: TLB miss for the current access (the TLB's `miss_o`).
- `vaddr_i` input, VADDR_SIZE: missing virtual page number.
- `access_type_i` input, `page_protection_e`: access type of the missing request.
- `ptbr_i` input, ADDR_SIZE: page-table base byte address.
- `flush_i` input, 1: abort any walk in progress (pipeline flush or TLB invalidate).
- `mem_req_o` output, 1: memory read request.
- `mem_addr_o` output, ADDR_SIZE: PTE byte address.
- `mem_gnt_i` input, 1: memory accepted the request this cycle.
- `mem_rvalid_i` input, 1: read data valid.
- `mem_rdata_i` input, 32: PTE.
- `tlb_new_entry_o` output, 1: TLB write strobe (drives the TLB's `new_entry_i`).
- `tlb_vaddr_o` output, VADDR_SIZE: VPN for the TLB write.
- `tlb_paddr_o` output, PADDR_SIZE: PPN for the TLB write.
- `tlb_prot_o` output, `page_protection_e`: protection for the TLB write. It is muxed onto the TLB's `access_type_i` while `tlb_new_entry_o` is high.
- `busy_o` output, 1: walk in progress (any state other than IDLE).
- `page_fault_o` output, 1: one-cycle pulse when the PTE is invalid.

## Operation
PTE format:
- bit 31: valid.
- bits [9:8]: `page_protection_e`.
- bits [PADDR_SIZE-1:0]: PPN.
- All other bits are ignored.

FSM states: IDLE, REQ, WAIT, DRAIN, FILL, FAULT.
- **IDLE**
  - On `miss_i`=1 and `flush_i`=0: latch `vaddr_i`, `ptbr_i` and `access_type_i`, then go to REQ.
  - `miss_i` is ignored in every other state.
- **REQ**
  - `mem_req_o`=1 and `mem_addr_o` = latched ptbr + (latched vpn << 2), truncated modulo 2^ADDR_SIZE.
  - Request and address are held stable until `mem_gnt_i`.
  - On `mem_gnt_i`: go to WAIT.
  - On `flush_i` without `mem_gnt_i`: go to IDLE. On `flush_i` with `mem_gnt_i`: go to DRAIN.
- **WAIT**
  - On `mem_rvalid_i`: capture `mem_rdata_i`. Go to FILL if bit 31=1, else to FAULT.
  - On `flush_i` without `mem_rvalid_i`: go to DRAIN. On `flush_i` with `mem_rvalid_i`: discard the data and go to IDLE.
- **DRAIN**
  - Wait for `mem_rvalid_i`, discard the data, go to IDLE.
  - `flush_i` has no further effect.
- **FILL**
  - `tlb_new_entry_o`=1 for exactly one cycle, then go to IDLE.
  - `tlb_vaddr_o` = latched VPN; `tlb_paddr_o` and `tlb_prot_o` come from the captured PTE.
- **FAULT**
  - `page_fault_o`=1 for exactly one cycle, then go to IDLE. No TLB write.

Flush in FILL or FAULT:
- `tlb_new_entry_o` and `page_fault_o` are combinationally masked by `flush_i`, then the FSM goes to IDLE.
- This is required because the TLB gives `new_entry_i` priority over `invalidate_i`; without the mask a stale fill would survive an invalidate.

Other rules:
- `tlb_*` data outputs are valid only while `tlb_new_entry_o`=1. Outside that cycle they hold their last value.
- At most one outstanding memory read exists at any time.

## Timing
- **Reset** (asynchronous, `rsn_i`=0):
  - state is IDLE.
  - `mem_req_o`, `tlb_new_entry_o`, `page_fault_o` and `busy_o` are 0.
  - `mem_addr_o`, `tlb_vaddr_o`, `tlb_paddr_o` and all internal latches are 0.
  - `tlb_prot_o`=R.
  - Reset mid-walk abandons the walk. Any later `mem_rvalid_i` is ignored while in IDLE.
- **Minimum latency:** miss sampled at cycle 0, REQ at cycle 1 (granted in the same cycle), WAIT at cycle 2 (rvalid in the same cycle), FILL at cycle 3. `tlb_new_entry_o` is high in cycle 3 and IDLE is back in cycle 4.
- **Latency under stalls:** each cycle of grant or rvalid delay adds one cycle.
- **`busy_o`:** 1 from cycle 1 until the cycle before IDLE is re-entered.
- **Back-to-back misses:** a miss held high into the first IDLE cycle after FILL starts a new walk. The requester deasserts `miss_i` once the TLB hits.

## Test plan
- **Hit path:** ptbr=0x1000, VPN=0x0000A, miss for one cycle, grant immediate, rdata=0x8000_020B one cycle later.
  - `mem_addr_o`=0x0000_1028.
  - FILL in cycle 3 with `tlb_paddr_o`=0x0B and `tlb_prot_o`=value 2 of `page_protection_e`.
  - `page_fault_o` stays 0.
- **Invalid PTE:** rdata=0x0000_020B.
  - `page_fault_o` pulses for one cycle, `tlb_new_entry_o` stays 0, state returns to IDLE.
- **Grant/rvalid stalls:** grant delayed 3 cycles, rvalid delayed 2 cycles.
  - `mem_req_o` and `mem_addr_o` are stable throughout REQ.
  - FILL occurs in cycle 8.
  - Exactly one request is issued.
- **Flush cases:**
  - Flush in REQ with no grant: back to IDLE, no memory traffic.
  - Flush in the grant cycle: DRAIN absorbs the later rvalid, no fill.
  - Flush during FILL: `tlb_new_entry_o`=0.
- **Reset and address wrap:**
  - `rsn_i` low in WAIT: all outputs are 0 immediately. A following rvalid produces no fill.
  - ptbr=0xFFFF_FFF0 with VPN=0x00005: `mem_addr_o`=0x0000_0004.
  - `miss_i` pulsed while busy: ignored.
